// File: rtl/div_pkg.sv
// Shared definitions for the divider requester block.
//   DIV_W        default operand/quotient width
//   ERR_*        status codes attached to each result entry
//   state_e      requester FSM states
//   res_entry_t  result entry layout {q, err} at the default width
//   err_code()   completion-pulse to status encoding (dvz > ovf > ok)
package div_pkg;

   localparam int unsigned DIV_W = 10;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_DVZ = 2'b01;
   localparam logic [1:0] ERR_OVF = 2'b10;
   localparam logic [1:0] ERR_TMO = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   typedef struct packed {
      logic [DIV_W-1:0] q;
      logic [1:0]       err;
   } res_entry_t;

   function automatic logic [1:0] err_code(input logic dvz, input logic ovf);
      if (dvz) begin
         return ERR_DVZ;
      end else if (ovf) begin
         return ERR_OVF;
      end
      return ERR_OK;
   endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Synchronous show-ahead FIFO holding tagged division results.
//   clk_i      clock, rising edge
//   sclr_ni    synchronous active-low clear (empties the FIFO)
//   push_i     write wdata_i (ignored when full)
//   wdata_i    entry to write
//   pop_i      drop the head entry (ignored when empty)
//   rdata_o    head entry, zero while empty
//   empty_o    no entries stored
//   full_o     Depth entries stored
//   count_o    occupancy
module div_result_fifo #(
   parameter int unsigned Width = 12,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       sclr_ni,
   input  logic                       push_i,
   input  logic [Width-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           rdata_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(Depth):0]     count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(Depth));
   assign count_o = count_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Masked while empty so the head reads as zero after a clear.
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

   always_comb begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!sclr_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk_i) begin
      if (sclr_ni && do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/div_requester.sv
// Initiator for the sequential divider handshake.
// Accepts operand pairs on req_*, launches one division at a time with a
// single-cycle div_start, holds div_a/div_b, waits for valid/dvz/ovf (or a
// watchdog timeout) and queues {quotient, status} into a result FIFO read
// out on res_*.
//   clk        clock, rising edge
//   sclr       synchronous active-low reset
//   req_*      upstream operand port (valid/ready)
//   div_*      divider launch outputs and completion inputs
//   res_*      downstream result port (valid/ready) plus occupancy
module div_requester
   import div_pkg::*;
#(
   parameter int unsigned W       = DIV_W,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                      clk,
   input  logic                      sclr,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [W-1:0]              req_a,
   input  logic [W-1:0]              req_b,
   output logic [W-1:0]              div_a,
   output logic [W-1:0]              div_b,
   output logic                      div_start,
   input  logic                      div_busy,
   input  logic                      div_valid,
   input  logic                      div_dvz,
   input  logic                      div_ovf,
   input  logic [W-1:0]              div_q,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [W-1:0]              res_q,
   output logic [1:0]                res_err,
   output logic [$clog2(DEPTH):0]    res_count
);

   localparam int unsigned WdW = $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

   state_e         state_q, state_d;
   logic [WdW-1:0] wdog_q, wdog_d;
   logic [W-1:0]   div_a_q, div_a_d;
   logic [W-1:0]   div_b_q, div_b_d;
   logic           div_start_q, div_start_d;

   logic           accept;
   logic           done;
   logic           push;
   logic [W-1:0]   push_q;
   logic [1:0]     push_err;
   logic [W+1:0]   head;
   logic           fifo_empty, fifo_full;
   logic           unused_busy;

   // Busy is informational only; completion is taken from the pulses.
   assign unused_busy = div_busy;

   // Reserving a free slot before issue guarantees the push never overflows.
   assign req_ready = sclr && (state_q == StIdle) && !fifo_full;
   assign accept    = req_valid && req_ready;
   assign done      = div_valid || div_dvz || div_ovf;

   always_comb begin
      state_d     = state_q;
      wdog_d      = wdog_q;
      div_a_d     = div_a_q;
      div_b_d     = div_b_q;
      div_start_d = 1'b0;
      push        = 1'b0;
      push_q      = '0;
      push_err    = ERR_OK;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               div_a_d     = req_a;
               div_b_d     = req_b;
               div_start_d = 1'b1;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            // Completion pulses are ignored here.
            wdog_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            if (done) begin
               push     = 1'b1;
               push_err = err_code(div_dvz, div_ovf);
               push_q   = (push_err == ERR_OK) ? div_q : '0;
               state_d  = StIdle;
            end else if (wdog_q == WdLast) begin
               // TIMEOUT-th WAIT cycle without a completion.
               push     = 1'b1;
               push_err = ERR_TMO;
               state_d  = StIdle;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sclr) begin
         state_q     <= StIdle;
         wdog_q      <= '0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         div_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wdog_q      <= wdog_d;
         div_a_q     <= div_a_d;
         div_b_q     <= div_b_d;
         div_start_q <= div_start_d;
      end
   end

   assign div_a     = div_a_q;
   assign div_b     = div_b_q;
   assign div_start = div_start_q;

   div_result_fifo #(
      .Width (W + 2),
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .sclr_ni (sclr),
      .push_i  (push),
      .wdata_i ({push_q, push_err}),
      .pop_i   (res_ready),
      .rdata_o (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (res_count)
   );

   assign res_valid = !fifo_empty;
   assign res_q     = head[W+1:2];
   assign res_err   = head[1:0];

endmodule

// File: tb/tb_div_requester.sv
module tb_div_requester;
   import div_pkg::*;

   logic       clk = 1'b0;
   logic       sclr;
   logic       req_valid, req_ready;
   logic [9:0] req_a, req_b, div_a, div_b;
   logic       div_start, div_busy, div_valid, div_dvz, div_ovf;
   logic [9:0] div_q;
   logic       res_valid, res_ready;
   logic [9:0] res_q;
   logic [1:0] res_err;
   logic [2:0] res_count;

   int total = 0;
   int bad   = 0;
   res_entry_t exp_q[$];

   always #5 clk = ~clk;

   div_requester #(
      .W       (10),
      .DEPTH   (4),
      .TIMEOUT (32)
   ) dut (
      .clk       (clk),
      .sclr      (sclr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_start (div_start),
      .div_busy  (div_busy),
      .div_valid (div_valid),
      .div_dvz   (div_dvz),
      .div_ovf   (div_ovf),
      .div_q     (div_q),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_q     (res_q),
      .res_err   (res_err),
      .res_count (res_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input logic [9:0] q, input logic [1:0] e);
      res_entry_t t;
      t.q   = q;
      t.err = e;
      exp_q.push_back(t);
   endtask

   // Scoreboard monitor: compare the head on every pop.
   always @(negedge clk) begin
      if (res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got q=%0d err=%0d expected no entry", res_q, res_err);
         end else begin
            res_entry_t e;
            e = exp_q.pop_front();
            check("res_q", 32'(res_q), 32'(e.q));
            check("res_err", 32'(res_err), 32'(e.err));
         end
      end
   end

   // Accept a pair, then verify the ISSUE cycle and the first WAIT cycle.
   // Returns #1 into the first WAIT cycle (T+2).
   task automatic send(input logic [9:0] a, input logic [9:0] b);
      int n = 0;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      check("accept_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      check("div_start_issue", 32'(div_start), 32'd1);
      check("div_a", 32'(div_a), 32'(a));
      check("div_b", 32'(div_b), 32'(b));
      tick();
      check("div_start_wait", 32'(div_start), 32'd0);
   endtask

   // Idle `extra` WAIT cycles, then pulse completion for one cycle.
   task automatic respond(input int extra, input logic v, input logic dz, input logic ov,
                          input logic [9:0] q);
      repeat (extra) tick();
      div_valid = v;
      div_dvz   = dz;
      div_ovf   = ov;
      div_q     = q;
      tick();
      div_valid = 1'b0;
      div_dvz   = 1'b0;
      div_ovf   = 1'b0;
      div_q     = '0;
   endtask

   task automatic drain();
      int n = 0;
      res_ready = 1'b1;
      while (res_count != 0 && n < 20) begin
         tick();
         n++;
      end
      check("drain_count", 32'(res_count), 32'd0);
   endtask

   initial begin
      int n;
      sclr      = 1'b0;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      div_busy  = 1'b0;
      div_valid = 1'b0;
      div_dvz   = 1'b0;
      div_ovf   = 1'b0;
      div_q     = '0;
      res_ready = 1'b1;

      // Reset values
      tick();
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_count", 32'(res_count), 32'd0);
      check("rst_div_start", 32'(div_start), 32'd0);
      check("rst_div_a", 32'(div_a), 32'd0);
      check("rst_res_q", 32'(res_q), 32'd0);
      check("rst_res_err", 32'(res_err), 32'd0);
      sclr = 1'b1;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Divide and drain: valid three cycles after start
      sb_push(10'd14, ERR_OK);
      send(10'd100, 10'd7);
      respond(2, 1'b1, 1'b0, 1'b0, 10'd14);
      check("ok_res_valid", 32'(res_valid), 32'd1);
      check("ok_count", 32'(res_count), 32'd1);
      tick();
      check("ok_drained", 32'(res_count), 32'd0);

      // Divide by zero at T+2, quotient forced to zero
      sb_push(10'd0, ERR_DVZ);
      send(10'd5, 10'd0);
      respond(0, 1'b0, 1'b1, 1'b0, 10'd123);
      // dvz and ovf together: dvz wins
      sb_push(10'd0, ERR_DVZ);
      send(10'd6, 10'd0);
      respond(1, 1'b1, 1'b1, 1'b1, 10'd55);
      // ovf alone
      sb_push(10'd0, ERR_OVF);
      send(10'd512, 10'd1);
      respond(0, 1'b0, 1'b0, 1'b1, 10'd77);
      tick();

      // Full FIFO
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb_push(10'(20 + i), ERR_OK);
         send(10'(40 + 2 * i), 10'd2);
         respond(0, 1'b1, 1'b0, 1'b0, 10'(20 + i));
      end
      check("full_count", 32'(res_count), 32'd4);
      req_valid = 1'b1;
      req_a     = 10'd48;
      req_b     = 10'd2;
      for (int i = 0; i < 3; i++) begin
         check("full_req_ready", 32'(req_ready), 32'd0);
         tick();
         check("full_no_start", 32'(div_start), 32'd0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("after_pop_ready", 32'(req_ready), 32'd1);
      check("after_pop_count", 32'(res_count), 32'd3);
      sb_push(10'd24, ERR_OK);
      send(10'd48, 10'd2);
      respond(0, 1'b1, 1'b0, 1'b0, 10'd24);
      check("refill_count", 32'(res_count), 32'd4);
      drain();

      // Timeout: stub never answers
      sb_push(10'd0, ERR_TMO);
      send(10'd9, 10'd3);
      n = 0;
      while (!res_valid && n < 100) begin
         tick();
         n++;
      end
      // T+2 -> T+34
      check("tmo_latency", 32'(n), 32'd32);
      check("tmo_idle_ready", 32'(req_ready), 32'd1);
      tick();
      sb_push(10'd10, ERR_OK);
      send(10'd50, 10'd5);
      respond(1, 1'b1, 1'b0, 1'b0, 10'd10);
      tick();

      // Reset mid-WAIT, late result must be dropped
      send(10'd77, 10'd7);
      tick();
      sclr = 1'b0;
      #1;
      check("sclr_req_ready", 32'(req_ready), 32'd0);
      tick();
      sclr = 1'b1;
      respond(0, 1'b1, 1'b0, 1'b0, 10'd11);
      check("mid_rst_count", 32'(res_count), 32'd0);
      check("mid_rst_valid", 32'(res_valid), 32'd0);
      check("mid_rst_div_a", 32'(div_a), 32'd0);
      check("mid_rst_div_b", 32'(div_b), 32'd0);
      check("mid_rst_start", 32'(div_start), 32'd0);
      check("mid_rst_res_q", 32'(res_q), 32'd0);
      check("mid_rst_res_err", 32'(res_err), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      sb_push(10'd4, ERR_OK);
      send(10'd8, 10'd2);
      respond(0, 1'b1, 1'b0, 1'b0, 10'd4);
      tick();

      // Simultaneous push and pop at count 2
      res_ready = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         sb_push(10'(i), ERR_OK);
         send(10'(i), 10'd1);
         respond(0, 1'b1, 1'b0, 1'b0, 10'(i));
      end
      check("pp_count_before", 32'(res_count), 32'd2);
      sb_push(10'd3, ERR_OK);
      send(10'd3, 10'd1);
      res_ready = 1'b1;
      respond(0, 1'b1, 1'b0, 1'b0, 10'd3);
      res_ready = 1'b0;
      check("pp_count_after", 32'(res_count), 32'd2);
      check("pp_head_q", 32'(res_q), 32'd2);
      check("pp_head_err", 32'(res_err), 32'd0);
      drain();

      tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
